tea_decryptor_core: RTL and testbench
=====================================

// Module: tea_decryptor_core
// PURPOSE
//  Iterative TEA block decryptor: accepts one 64-bit ciphertext + 128-bit key, runs ROUNDS
//  full decryption rounds (one round/clk), returns 64-bit plaintext. Each round is
//  half-round 1 (V1 update, k2/k3) then half-round 2 (V0 update, k0/k1).
//  Sits between the key/data loader and the output buffer, with valid/ready on both sides.
// PARAMETERS
//  ROUNDS  32            number of full rounds (>=1)
//  DELTA   32'h9E3779B9  TEA key-schedule constant
// PORTS
//  clk        in   1    single clock, rising edge
//  rst        in   1    asynchronous, active-high reset
//  in_valid   in   1    in_block/in_key valid
//  in_ready   out  1    core can accept a block
//  in_key     in   128  k0=[31:0] k1=[63:32] k2=[95:64] k3=[127:96]
//  in_block   in   64   ciphertext, V0=[31:0] (LS), V1=[63:32] (MS)
//  out_valid  out  1    out_block holds plaintext
//  out_ready  in   1    consumer accepts out_block
//  out_block  out  64   plaintext, same V0/V1 packing
//  busy       out  1    high in RUN
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, busy=0, out_block=0,
//   internal V0/V1/key/sum/count regs=0. Mid-operation reset drops the block, no output.
//  F(x,kL,kR,s) = ((x<<4)+kL) ^ (x+s) ^ ((x>>5)+kR); all arithmetic mod 2^32, logical shift.
//  SUM_INIT = DELTA*ROUNDS truncated to 32 bits (32'hC6EF3720 for defaults).
//  FSM:
//   IDLE: in_ready=1. in_valid&&in_ready -> latch key, V0, V1; sum=SUM_INIT;
//         cnt=ROUNDS-1; -> RUN. in_key/in_block may change after this edge.
//   RUN:  in_ready=0, busy=1. Per clk:
//         V1n = V1 - F(V0, k2, k3, sum); V0n = V0 - F(V1n, k0, k1, sum);
//         V0<=V0n; V1<=V1n; sum<=sum-DELTA; cnt<=cnt-1.
//         Round with cnt==0: load out_block={V1n,V0n}, out_valid<=1 -> DONE.
//   DONE: out_valid=1, in_ready=0; out_block stable until handshake.
//         out_valid&&out_ready -> out_valid<=0 -> IDLE (in_ready=1 on next cycle).
//  Latency: acceptance edge E -> out_valid high after edge E+ROUNDS.
//   Throughput: one block per ROUNDS+2 cycles with out_ready held high.
//  in_valid ignored outside IDLE (no queueing); input not accepted in the cycle of output
//   handshake. out_ready ignored when out_valid=0. sum wraps mod 2^32; final sum=0 is
//   not checked. cnt sized $clog2(ROUNDS) (min 1 bit).
// STRUCTURE
//  Shared package tea_pkg: TEA_DELTA, TEA_ROUNDS_DEFAULT, function tea_sum_init(rounds),
//   typedef'd state encoding {IDLE, RUN, DONE} and 64/128-bit block/key widths.
//  One sub-module: tea_dec_round (combinational, one full round: inputs V0,V1,key,sum;
//   outputs V0n,V1n) built from the existing decryptor_half_round_1 and
//   decryptor_half_round_2 blocks in series. FSM, counter, sum and data regs live in the top.
// TESTING
//  1. Key=0, in_block={V1=32'h94BAA940,V0=32'h41EA3A0A} -> out_block=64'h0 exactly
//     ROUNDS cycles after accept; out_valid held until out_ready.
//  2. Random key/plaintext: encrypt in C/SV model, feed ciphertext -> plaintext matches;
//     1000 blocks, out_ready randomly throttled, no loss/duplication, out_block stable.
//  3. in_valid held high during RUN/DONE with changing in_block/in_key -> in_ready=0,
//     result unaffected; next block accepted only after output handshake.
//  4. Assert rst at round 10 of a block -> all outputs to reset values same cycle;
//     no out_valid; next block after deassert decrypts correctly.
//  5. ROUNDS=1 and ROUNDS=16 builds: sum starts at DELTA*ROUNDS; latency = ROUNDS;
//     result matches the reference model with the same round count.
//  6. Back-to-back with out_ready=1: accept spacing = ROUNDS+2 cycles, busy high ROUNDS cycles.

Source files
------------

// File: rtl/tea_pkg.sv
// Shared TEA constants, state encoding and the round function used by the decryptor.
package tea_pkg;

  localparam int unsigned BlockW = 64;
  localparam int unsigned KeyW   = 128;

  localparam logic [31:0] TEA_DELTA          = 32'h9E3779B9;
  localparam int unsigned TEA_ROUNDS_DEFAULT = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } tea_state_e;

  // Starting sum for decryption: DELTA*rounds truncated to 32 bits.
  function automatic logic [31:0] tea_sum_init(input int unsigned rounds,
                                               input logic [31:0] delta = TEA_DELTA);
    return delta * rounds;
  endfunction

  function automatic logic [31:0] tea_f(input logic [31:0] x, input logic [31:0] kl,
                                        input logic [31:0] kr, input logic [31:0] s);
    return ((x << 4) + kl) ^ (x + s) ^ ((x >> 5) + kr);
  endfunction

endpackage

// File: rtl/tea_dec_round.sv
// One full TEA decryption round: V1 half-round (k2/k3) followed by V0 half-round (k0/k1).
module tea_dec_round
  import tea_pkg::*;
(
  input  logic [31:0]     v0,
  input  logic [31:0]     v1,
  input  logic [KeyW-1:0] key,
  input  logic [31:0]     sum,
  output logic [31:0]     v0n,
  output logic [31:0]     v1n
);

  logic [31:0] half1_v1;
  logic [31:0] half2_v0;

  assign half1_v1 = v1 - tea_f(v0, key[95:64], key[127:96], sum);
  // Second half consumes the freshly updated V1 within the same cycle.
  assign half2_v0 = v0 - tea_f(half1_v1, key[31:0], key[63:32], sum);

  assign v1n = half1_v1;
  assign v0n = half2_v0;

endmodule

// File: rtl/tea_decryptor_core.sv
// Iterative TEA block decryptor, one full round per clock, valid/ready on both sides.
module tea_decryptor_core
  import tea_pkg::*;
#(
  parameter int unsigned ROUNDS = TEA_ROUNDS_DEFAULT,
  parameter logic [31:0] DELTA  = TEA_DELTA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [KeyW-1:0]   in_key,
  input  logic [BlockW-1:0] in_block,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BlockW-1:0] out_block,
  output logic              busy
);

  localparam int unsigned     CntW    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(ROUNDS - 1);
  localparam logic [31:0]     SumInit = tea_sum_init(ROUNDS, DELTA);

  tea_state_e        state_q, state_d;
  logic [31:0]       v0_q, v0_d, v1_q, v1_d, sum_q, sum_d;
  logic [KeyW-1:0]   key_q, key_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BlockW-1:0] out_block_q, out_block_d;
  logic [31:0]       v0n, v1n;

  tea_dec_round u_round (
    .v0  (v0_q),
    .v1  (v1_q),
    .key (key_q),
    .sum (sum_q),
    .v0n (v0n),
    .v1n (v1n)
  );

  always_comb begin
    state_d     = state_q;
    v0_d        = v0_q;
    v1_d        = v1_q;
    sum_d       = sum_q;
    key_d       = key_q;
    cnt_d       = cnt_q;
    out_block_d = out_block_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          key_d   = in_key;
          v0_d    = in_block[31:0];
          v1_d    = in_block[63:32];
          sum_d   = SumInit;
          cnt_d   = CntInit;
          state_d = StRun;
        end
      end
      StRun: begin
        v0_d  = v0n;
        v1_d  = v1n;
        sum_d = sum_q - DELTA;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          out_block_d = {v1n, v0n};
          state_d     = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      v0_q        <= '0;
      v1_q        <= '0;
      sum_q       <= '0;
      key_q       <= '0;
      cnt_q       <= '0;
      out_block_q <= '0;
    end else begin
      state_q     <= state_d;
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      sum_q       <= sum_d;
      key_q       <= key_d;
      cnt_q       <= cnt_d;
      out_block_q <= out_block_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q == StRun);
  assign out_valid = (state_q == StDone);
  assign out_block = out_block_q;

endmodule

// File: tb/tb_tea_decryptor_core.sv
// Directed bench for tea_decryptor_core: known vector, encrypt-model vectors and handshake corners.
module tb_tea_decryptor_core;

  localparam int unsigned ROUNDS = 32;
  localparam logic [31:0] DELTA  = 32'h9E3779B9;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_key = '0;
  logic [63:0]  in_block = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [63:0]  out_block;
  logic         busy;

  int checks = 0;
  int errors = 0;

  tea_decryptor_core #(
    .ROUNDS (ROUNDS),
    .DELTA  (DELTA)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_key    (in_key),
    .in_block  (in_block),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic [63:0]  ct;
    logic [63:0]  pt;
  } vec_t;

  // Reference TEA encryption, independent of the decrypt datapath.
  function automatic logic [63:0] tea_enc(input logic [127:0] k, input logic [63:0] p);
    logic [31:0] v0 = p[31:0];
    logic [31:0] v1 = p[63:32];
    logic [31:0] s  = '0;
    for (int i = 0; i < ROUNDS; i++) begin
      s  = s + DELTA;
      v0 = v0 + (((v1 << 4) + k[31:0]) ^ (v1 + s) ^ ((v1 >> 5) + k[63:32]));
      v1 = v1 + (((v0 << 4) + k[95:64]) ^ (v0 + s) ^ ((v0 >> 5) + k[127:96]));
    end
    return {v1, v0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Send one block, verify latency/result, stall the output, then hand it off.
  task automatic run_block(input logic [127:0] key, input logic [63:0] ct,
                           input logic [63:0] pt, input int stall, input bit hold);
    int lat;
    @(negedge clk);
    in_key   = key;
    in_block = ct;
    in_valid = 1'b1;
    check("in_ready_idle", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
    in_key   = {$urandom, $urandom, $urandom, $urandom};
    in_block = {$urandom, $urandom};
    lat = 0;
    while (!out_valid && lat < ROUNDS + 4) begin
      @(posedge clk);
      #1;
      lat++;
      if (hold) begin
        in_key   = {$urandom, $urandom, $urandom, $urandom};
        in_block = {$urandom, $urandom};
        check("in_ready_low_run", 64'(in_ready), 64'd0);
      end
    end
    check("latency", 64'(lat), 64'(ROUNDS));
    check("out_block", out_block, pt);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check("out_valid_held", 64'(out_valid), 64'd1);
      check("out_block_stable", out_block, pt);
      check("in_ready_done", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("out_valid_drop", 64'(out_valid), 64'd0);
    check("in_ready_after", 64'(in_ready), 64'd1);
    check("busy_after", 64'(busy), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_out_block"}, out_block, 64'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int seen;
    int accepts[$];
    int busy_cnt;
    int a0, a1;
    logic [127:0] bk;
    logic [63:0]  bp, bc;

    vecs[0] = '{key: '0, ct: {32'h94BAA940, 32'h41EA3A0A}, pt: '0};
    vecs[1] = '{key: 128'h0, ct: '0, pt: 64'h0000_0001_0000_0000};
    vecs[2] = '{key: 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, ct: '0, pt: 64'hFFFFFFFF_FFFFFFFF};
    vecs[3] = '{key: 128'h01234567_89ABCDEF_FEDCBA98_76543210, ct: '0, pt: 64'hDEADBEEF_CAFEF00D};
    vecs[4] = '{key: 128'h00000004_00000003_00000002_00000001, ct: '0, pt: 64'h12345678_9ABCDEF0};
    vecs[5] = '{key: 128'h80000000_00000001_7FFFFFFF_A5A5A5A5, ct: '0, pt: 64'h00000000_00000001};
    for (int i = 1; i < 6; i++) vecs[i].ct = tea_enc(vecs[i].key, vecs[i].pt);

    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_block(vecs[i].key, vecs[i].ct, vecs[i].pt, i % 3, 1'b0);

    // Inputs held valid and changing during RUN/DONE must be ignored.
    run_block(vecs[3].key, vecs[3].ct, vecs[3].pt, 2, 1'b1);

    // Random blocks with randomly throttled consumer.
    for (int i = 0; i < 8; i++) begin
      bk = {$urandom, $urandom, $urandom, $urandom};
      bp = {$urandom, $urandom};
      run_block(bk, tea_enc(bk, bp), bp, int'($urandom_range(0, 3)), 1'b0);
    end

    // Reset during round 10 drops the block.
    @(negedge clk);
    in_key   = vecs[4].key;
    in_block = vecs[4].ct;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < ROUNDS + 4; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("midrst_no_output", 64'(seen), 64'd0);
    run_block(vecs[5].key, vecs[5].ct, vecs[5].pt, 1, 1'b0);

    // Back-to-back with consumer always ready.
    bk = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    bp = 64'h0BADC0DE_FEEDFACE;
    bc = tea_enc(bk, bp);
    busy_cnt = 0;
    @(negedge clk);
    in_key    = bk;
    in_block  = bc;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 3 * (ROUNDS + 2); c++) begin
      if (in_valid && in_ready) accepts.push_back(c);
      if (busy && accepts.size() == 1) busy_cnt++;
      if (out_valid) check("b2b_out_block", out_block, bp);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_accepts", 64'(accepts.size() >= 2), 64'd1);
    a0 = (accepts.size() >= 2) ? accepts[0] : 0;
    a1 = (accepts.size() >= 2) ? accepts[1] : 0;
    check("b2b_spacing", 64'(a1 - a0), 64'(ROUNDS + 2));
    check("b2b_busy_cycles", 64'(busy_cnt), 64'(ROUNDS));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
